core_seq: RTL and testbench

Multi-cycle sequencer for the single-issue RV32I core. It steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB. It handshakes with the instruction and data buses, and it gates the IR, PC and register-file write enables using the control bits produced by the instruction decoder. It sits between the decoder/branch unit and the core's memory ports, and it keeps a retired-instruction counter.

---
 rtl/core_seq_if.sv | 19 +
 rtl/core_seq.sv | 123 ++++++++++++
 tb/tb_core_seq.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_seq_if.sv
// Instruction/data bus handshake bundle for core_seq.
// master = sequencer side, slave = memory side.
interface core_seq_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, dmem_ack
  );
endinterface

// File: rtl/core_seq.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB + instret.
// Optional bus watchdog and ERR state under `define BUS_TIMEOUT_EN.
module core_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  core_seq_if.master  bus,
  input  logic        mem_load,
  input  logic        mem_wr,
  input  logic        reg_wr,
  input  logic        branch_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        rf_we,
  output logic        rf_wsrc,
  output logic        busy,
  output logic [31:0] instret,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    ERR
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CW_REQ = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_REQ > 8) ? CW_REQ : 8;

  logic [CW-1:0] wait_cnt;
  logic          enter_wait;
  logic          no_ack;

  assign enter_wait = (state_nxt != state) &&
                      ((state_nxt == FETCH) || (state_nxt == MEM));
  assign no_ack = ((state == FETCH) && !bus.imem_ack) ||
                  ((state == MEM)   && !bus.dmem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          wait_cnt <= '0;
    else if (enter_wait) wait_cnt <= '0;
    else if (no_ack)     wait_cnt <= wait_cnt + 1'b1;
  end

  // An ack in the limit cycle takes priority over the timeout.
  assign timeout = (wait_cnt == CW'(TIMEOUT_CYCLES));
  assign bus_err = (state == ERR);
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    rf_we        = 1'b0;
    rf_wsrc      = 1'b0;
    unique case (state)
      IDLE: begin
        if (run) state_nxt = FETCH;
      end
      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_we     = 1'b1;
          state_nxt = DECODE;
        end else if (timeout) begin
          state_nxt = ERR;
        end
      end
      DECODE: state_nxt = EXEC;
      EXEC: begin
        state_nxt = (mem_load || mem_wr) ? MEM : WB;
      end
      MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = mem_wr;
        if (bus.dmem_ack)  state_nxt = WB;
        else if (timeout)  state_nxt = ERR;
      end
      WB: begin
        // load+store together behaves as a store
        rf_we     = reg_wr & ~mem_wr;
        rf_wsrc   = mem_load & ~mem_wr;
        pc_we     = 1'b1;
        pc_sel    = branch_taken;
        state_nxt = run ? FETCH : IDLE;
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE) && (state != ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           instret <= '0;
    else if (state == WB) instret <= instret + 32'd1;
  end

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq (scoreboard of per-instruction records).
// Timeout scenario runs only when BUS_TIMEOUT_EN is defined.
module tb_core_seq;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        mem_load;
  logic        mem_wr;
  logic        reg_wr;
  logic        branch_taken;
  logic        ir_we;
  logic        pc_we;
  logic        pc_sel;
  logic        rf_we;
  logic        rf_wsrc;
  logic        busy;
  logic [31:0] instret;
  logic        bus_err;

  core_seq_if bus ();

  core_seq #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .bus          (bus),
    .mem_load     (mem_load),
    .mem_wr       (mem_wr),
    .reg_wr       (reg_wr),
    .branch_taken (branch_taken),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .rf_wsrc      (rf_wsrc),
    .busy         (busy),
    .instret      (instret),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rf_we;
    logic       rf_wsrc;
    logic       pc_sel;
    logic       dmem_we;
    logic [7:0] lat;
    logic [7:0] ireq;
    logic [7:0] dreq;
    logic [7:0] irwe;
  } rec_t;

  rec_t        sb[$];
  int          n_chk;
  int          n_fail;
  logic [31:0] exp_instret;

  function automatic void push_exp(input bit ld, st, rw, br,
                                   input int iw, dw);
    rec_t e;
    int   m;
    m         = (ld || st) ? 1 : 0;
    e.rf_we   = rw & ~st;
    e.rf_wsrc = ld & ~st;
    e.pc_sel  = br;
    e.dmem_we = st;
    e.lat     = 8'(4 + m + iw + (m != 0 ? dw : 0));
    e.ireq    = 8'(iw + 1);
    e.dreq    = (m != 0) ? 8'(dw + 1) : 8'd0;
    e.irwe    = 8'd1;
    sb.push_back(e);
    exp_instret = exp_instret + 32'd1;
  endfunction

  task automatic do_reset();
    rst_n        = 1'b0;
    run          = 1'b0;
    mem_load     = 1'b0;
    mem_wr       = 1'b0;
    reg_wr       = 1'b0;
    branch_taken = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    exp_instret = '0;
    sb.delete();
  endtask

  // Drives one instruction starting at a negedge and records what the DUT did.
  task automatic exec(input bit ld, st, rw, br, input int iw, dw,
                      input bit keep, output rec_t o,
                      output int fetch, output bit ok);
    int ic;
    int dc;
    int irc;
    ic    = 0;
    dc    = 0;
    irc   = -1;
    o     = '0;
    fetch = -1;
    ok    = 1'b0;
    mem_load     = ld;
    mem_wr       = st;
    reg_wr       = rw;
    branch_taken = br;
    run          = 1'b1;
    for (int cyc = 0; cyc < 200 && !ok; cyc++) begin
      bus.imem_ack = bus.imem_req && (ic == iw);
      bus.dmem_ack = bus.dmem_req && (dc == dw);
      #1;
      if (bus.imem_req) begin
        if (fetch < 0) fetch = cyc;
        ic++;
      end
      if (bus.dmem_req) begin
        dc++;
        o.dmem_we = bus.dmem_we;
      end
      if (ir_we) begin
        o.irwe = o.irwe + 8'd1;
        irc    = cyc;
      end
      if (irc >= 0 && cyc == irc + 2) run = keep;
      if (pc_we) begin
        o.rf_we   = rf_we;
        o.rf_wsrc = rf_wsrc;
        o.pc_sel  = pc_sel;
        o.lat     = 8'(cyc - fetch + 1);
        ok        = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      @(negedge clk);
    end
    o.ireq = 8'(ic);
    o.dreq = 8'(dc);
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    rst_n = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    #1;
    outs = {bus.imem_req, bus.dmem_req, bus.dmem_we, ir_we, pc_we,
            pc_sel, rf_we, rf_wsrc, busy, bus_err};
    n_chk++;
    if (outs !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 0", outs);
    end
    n_chk++;
    if (instret !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_instret: got %h want 0", instret);
    end
    do_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_run: busy=%b req=%b want 0 0",
               busy, bus.imem_req);
    end
  endtask

  task automatic test_addi();
    rec_t o, e;
    int   f;
    bit   ok;
    push_exp(0, 0, 1, 0, 0, 0);
    exec(0, 0, 1, 0, 0, 0, 0, o, f, ok);
    e = sb.pop_front();
    n_chk++;
    if (!ok || o !== e) begin
      n_fail++;
      $display("FAIL addi: got %h ok=%0b want %h", o, ok, e);
    end
    n_chk++;
    if (f !== 1) begin
      n_fail++;
      $display("FAIL addi_fetch_cycle: got %0d want 1", f);
    end
    n_chk++;
    if (instret !== exp_instret) begin
      n_fail++;
      $display("FAIL addi_instret: got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_load();
    rec_t o, e;
    int   f;
    bit   ok;
    push_exp(1, 0, 1, 0, 0, 3);
    exec(1, 0, 1, 0, 0, 3, 0, o, f, ok);
    e = sb.pop_front();
    n_chk++;
    if (!ok || o !== e) begin
      n_fail++;
      $display("FAIL lw_wait3: got %h ok=%0b want %h", o, ok, e);
    end
    n_chk++;
    if (instret !== exp_instret) begin
      n_fail++;
      $display("FAIL lw_instret: got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_back_to_back();
    rec_t o, e;
    int   f;
    bit   ok;
    bit   tb_ld[4] = '{0, 0, 1, 0};
    bit   tb_st[4] = '{1, 0, 1, 0};
    bit   tb_rw[4] = '{0, 0, 1, 1};
    bit   tb_br[4] = '{0, 1, 0, 0};
    int   tb_iw[4] = '{0, 0, 1, 2};
    int   tb_dw[4] = '{0, 0, 2, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_exp(tb_ld[i], tb_st[i], tb_rw[i], tb_br[i], tb_iw[i], tb_dw[i]);
      exec(tb_ld[i], tb_st[i], tb_rw[i], tb_br[i], tb_iw[i], tb_dw[i],
           (i != 3), o, f, ok);
      e = sb.pop_front();
      n_chk++;
      if (!ok || o !== e) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %h ok=%0b want %h", i, o, ok, e);
      end
      n_chk++;
      if (f !== ((i == 0) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL b2b_%0d_bubble: fetch at %0d want %0d",
                 i, f, (i == 0) ? 1 : 0);
      end
      if (i == 1) begin
        n_chk++;
        if (instret !== 32'd2) begin
          n_fail++;
          $display("FAIL b2b_instret2: got %0d want 2", instret);
        end
      end
    end
    n_chk++;
    if (instret !== exp_instret) begin
      n_fail++;
      $display("FAIL b2b_instret: got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_run_drop();
    rec_t o, e;
    int   f;
    bit   ok;
    push_exp(0, 0, 1, 1, 0, 0);
    exec(0, 0, 1, 1, 0, 0, 0, o, f, ok);
    e = sb.pop_front();
    n_chk++;
    if (!ok || o !== e) begin
      n_fail++;
      $display("FAIL run_drop_instr: got %h ok=%0b want %h", o, ok, e);
    end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (busy !== 1'b0 || bus.imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL run_drop_idle_%0d: busy=%b req=%b want 0 0",
                 i, busy, bus.imem_req);
      end
      @(negedge clk);
    end
    run = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL run_restart: busy=%b req=%b want 1 1",
               busy, bus.imem_req);
    end
    do_reset();
  endtask

  task automatic test_bus_wait();
    rec_t o, e;
    int   f;
    bit   ok;
    int   iw;
    int   dw;
`ifdef BUS_TIMEOUT_EN
    iw = TMO;
    dw = TMO;
`else
    iw = 20;
    dw = 30;
`endif
    push_exp(1, 0, 1, 0, iw, dw);
    exec(1, 0, 1, 0, iw, dw, 0, o, f, ok);
    e = sb.pop_front();
    n_chk++;
    if (!ok || o !== e) begin
      n_fail++;
      $display("FAIL bus_wait: got %h ok=%0b want %h", o, ok, e);
    end
    n_chk++;
    if (bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bus_wait_err: got %b want 0", bus_err);
    end
  endtask

  task automatic test_reset_mid();
    rec_t o, e;
    int   f;
    bit   ok;
    push_exp(0, 0, 1, 0, 0, 0);
    exec(0, 0, 1, 0, 0, 0, 0, o, f, ok);
    e = sb.pop_front();
    n_chk++;
    if (!ok || o !== e) begin
      n_fail++;
      $display("FAIL pre_reset_instr: got %h ok=%0b want %h", o, ok, e);
    end
    mem_load = 1'b1;
    mem_wr   = 1'b0;
    reg_wr   = 1'b1;
    run      = 1'b1;
    for (int i = 0; i < 20 && !bus.dmem_req; i++) begin
      bus.imem_ack = bus.imem_req;
      @(posedge clk);
      #1 bus.imem_ack = 1'b0;
      @(negedge clk);
    end
    n_chk++;
    if (bus.dmem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_mem: dmem_req=%b want 1", bus.dmem_req);
    end
    run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.dmem_req !== 1'b0 || busy !== 1'b0 || instret !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: req=%b busy=%b instret=%0d want 0 0 0",
               bus.dmem_req, busy, instret);
    end
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    rst_n       = 1'b1;
    exp_instret = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus.dmem_req !== 1'b0 || busy !== 1'b0 || pc_we !== 1'b0 ||
          instret !== exp_instret) begin
        n_fail++;
        $display("FAIL late_ack_%0d: req=%b busy=%b pc_we=%b instret=%0d",
                 i, bus.dmem_req, busy, pc_we, instret);
      end
    end
    bus.dmem_ack = 1'b0;
    mem_load     = 1'b0;
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    int reqs;
    do_reset();
    reg_wr = 1'b1;
    run    = 1'b1;
    reqs   = 0;
    for (int i = 0; i < 50 && !bus_err; i++) begin
      #1;
      if (bus.imem_req) reqs++;
      @(negedge clk);
    end
    n_chk++;
    if (reqs !== TMO + 1) begin
      n_fail++;
      $display("FAIL tmo_req_cycles: got %0d want %0d", reqs, TMO + 1);
    end
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++;
      if (bus_err !== 1'b1 || busy !== 1'b0 || bus.imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_err_%0d: err=%b busy=%b req=%b want 1 0 0",
                 i, bus_err, busy, bus.imem_req);
      end
      @(negedge clk);
    end
    do_reset();
    #1;
    n_chk++;
    if (bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear: got %b want 0", bus_err);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    exp_instret  = '0;
    rst_n        = 1'b0;
    run          = 1'b0;
    mem_load     = 1'b0;
    mem_wr       = 1'b0;
    reg_wr       = 1'b0;
    branch_taken = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    test_reset();
    test_addi();
    test_load();
    test_back_to_back();
    test_run_drop();
    test_bus_wait();
    test_reset_mid();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
